// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: drives the fetch PC, talks to instruction memory and
// feeds {instruction, pc+1} pairs to IF/ID through a 2-entry prefetch buffer.
module if_fetch_unit #(
  parameter int                   PC_W      = 8,
  parameter int                   INSTR_W   = 19,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               IF_IDwrite,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] IF_instruction,
  output logic [PC_W-1:0]    IF_pc_plus_one,
  output logic               IF_valid
);

  // state | meaning
  // IDLE  | no request outstanding; issue when a buffer slot is (or becomes) free
  // WAIT  | request outstanding; response is pushed into the buffer
  // DRAIN | request outstanding on a stale path; response is dropped
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t             state, state_d;
  logic [PC_W-1:0]    fetch_pc, fetch_pc_d;
  logic [PC_W-1:0]    req_pc, req_pc_d;
  logic [1:0]         count, count_d;
  logic [INSTR_W-1:0] buf_instr [2];
  logic [PC_W-1:0]    buf_ppo   [2];
  logic               valid, pop, push, push_slot;

  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    req_pc_d   = req_pc;
    push       = 1'b0;
    valid      = (count != 2'd0) && !redirect;
    pop        = valid && IF_IDwrite;
    case (state)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if ((count < 2'd2) || pop) begin
          req_pc_d   = fetch_pc;
          fetch_pc_d = fetch_pc + PC_W'(1);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = imem_ack ? S_IDLE : S_DRAIN;
        end else if (imem_ack) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (redirect) fetch_pc_d = redirect_pc;
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count + 2'd1;
        2'b01:   count_d = count - 2'd1;
        default: count_d = count;
      endcase
    end
    // A free slot is guaranteed on push, so the tail is slot 1 only when
    // one word stays resident this cycle.
    push_slot = (count == 2'd1) && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      fetch_pc     <= RESET_PC;
      req_pc       <= RESET_PC;
      count        <= 2'd0;
      buf_instr[0] <= NOP_INSTR;
      buf_instr[1] <= NOP_INSTR;
      buf_ppo[0]   <= '0;
      buf_ppo[1]   <= '0;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      req_pc   <= req_pc_d;
      count    <= count_d;
      if (pop) begin
        buf_instr[0] <= buf_instr[1];
        buf_ppo[0]   <= buf_ppo[1];
      end
      if (push) begin
        if (push_slot) begin
          buf_instr[1] <= imem_rdata;
          buf_ppo[1]   <= req_pc + PC_W'(1);
        end else begin
          buf_instr[0] <= imem_rdata;
          buf_ppo[0]   <= req_pc + PC_W'(1);
        end
      end
    end
  end

  assign imem_req       = (state == S_WAIT) || (state == S_DRAIN);
  assign imem_addr      = req_pc;
  assign IF_valid       = valid;
  assign IF_instruction = valid ? buf_instr[0] : NOP_INSTR;
  assign IF_pc_plus_one = valid ? buf_ppo[0] : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vectors with hand-computed
// expected outputs, plus a hand-written reset-during-request sequence.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        IF_IDwrite = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [18:0] imem_rdata = '0;
  logic [18:0] IF_instruction;
  logic [7:0]  IF_pc_plus_one;
  logic        IF_valid;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .IF_IDwrite(IF_IDwrite), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IF_instruction(IF_instruction),
    .IF_pc_plus_one(IF_pc_plus_one), .IF_valid(IF_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        redir;
    logic [7:0]  rpc;
    logic        wr;
    logic        ack;
    logic [18:0] rdata;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [18:0] e_instr;
    logic [7:0]  e_ppo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic redir, input logic [7:0] rpc,
                     input logic wr, input logic ack, input logic [18:0] rdata,
                     input logic e_req, input logic [7:0] e_addr, input logic e_valid,
                     input logic [18:0] e_instr, input logic [7:0] e_ppo);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.wr = wr; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr; v.e_ppo = e_ppo;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic check_out(input vec_t v, input int idx);
    chk("imem_req", idx, 32'(imem_req), 32'(v.e_req));
    chk("imem_addr", idx, 32'(imem_addr), 32'(v.e_addr));
    chk("IF_valid", idx, 32'(IF_valid), 32'(v.e_valid));
    chk("IF_instruction", idx, 32'(IF_instruction), 32'(v.e_instr));
    chk("IF_pc_plus_one", idx, 32'(IF_pc_plus_one), 32'(v.e_ppo));
  endtask

  // Leaves rst_n released right at a falling edge, so the next rising edge is cycle 0.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect = 1'b0; redirect_pc = '0; IF_IDwrite = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    if (v.rst) do_reset();
    else @(negedge clk);
    redirect = v.redir; redirect_pc = v.rpc; IF_IDwrite = v.wr;
    imem_ack = v.ack; imem_rdata = v.rdata;
    #1;
    check_out(v, idx);
  endtask

  function automatic vec_t mk(input logic wr, input logic ack, input logic [18:0] rdata,
                              input logic e_req, input logic [7:0] e_addr, input logic e_valid,
                              input logic [18:0] e_instr, input logic [7:0] e_ppo);
    vec_t v;
    v = '0;
    v.wr = wr; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr; v.e_ppo = e_ppo;
    return v;
  endfunction

  initial begin
    // zero-wait memory, IF/ID always writing
    add(1,0,8'h00,1,0,19'h0,   0,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,1,1,19'h100, 1,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,1,0,19'h0,   0,8'h00,1,19'h100,8'h01);
    add(0,0,8'h00,1,1,19'h101, 1,8'h01,0,19'h0,8'h00);
    add(0,0,8'h00,1,0,19'h0,   0,8'h01,1,19'h101,8'h02);
    add(0,0,8'h00,1,1,19'h102, 1,8'h02,0,19'h0,8'h00);
    add(0,0,8'h00,1,0,19'h0,   0,8'h02,1,19'h102,8'h03);
    // IF/ID stalled for 10 cycles: buffer fills, then drains in order
    add(1,0,8'h00,0,0,19'h0,   0,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,0,1,19'h100, 1,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,0,0,19'h0,   0,8'h00,1,19'h100,8'h01);
    add(0,0,8'h00,0,1,19'h101, 1,8'h01,1,19'h100,8'h01);
    for (int i = 0; i < 6; i++)
      add(0,0,8'h00,0,0,19'h0, 0,8'h01,1,19'h100,8'h01);
    add(0,0,8'h00,1,0,19'h0,   0,8'h01,1,19'h100,8'h01);
    add(0,0,8'h00,1,1,19'h102, 1,8'h02,1,19'h101,8'h02);
    add(0,0,8'h00,1,0,19'h0,   0,8'h02,1,19'h102,8'h03);
    add(0,0,8'h00,1,0,19'h0,   1,8'h03,0,19'h0,8'h00);
    // memory ack delayed 3 cycles
    add(1,0,8'h00,1,0,19'h0,   0,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,1,0,19'h0,   1,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,1,0,19'h0,   1,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,1,0,19'h0,   1,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,1,1,19'h100, 1,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,1,0,19'h0,   0,8'h00,1,19'h100,8'h01);
    add(0,0,8'h00,1,0,19'h0,   1,8'h01,0,19'h0,8'h00);
    add(0,0,8'h00,1,0,19'h0,   1,8'h01,0,19'h0,8'h00);
    // redirect in WAIT to 40, re-redirect in DRAIN to 50, stale word dropped
    add(1,0,8'h00,1,0,19'h0,   0,8'h00,0,19'h0,8'h00);
    add(0,1,8'h40,1,0,19'h0,   1,8'h00,0,19'h0,8'h00);
    add(0,1,8'h50,1,0,19'h0,   1,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,1,1,19'h100, 1,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,1,0,19'h0,   0,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,1,1,19'h150, 1,8'h50,0,19'h0,8'h00);
    add(0,0,8'h00,1,0,19'h0,   0,8'h50,1,19'h150,8'h51);
    // redirect coinciding with ack and a waiting head word
    add(1,0,8'h00,0,0,19'h0,   0,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,0,1,19'h100, 1,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,0,0,19'h0,   0,8'h00,1,19'h100,8'h01);
    add(0,1,8'h80,1,1,19'h101, 1,8'h01,0,19'h0,8'h00);
    add(0,0,8'h00,1,0,19'h0,   0,8'h01,0,19'h0,8'h00);
    add(0,0,8'h00,1,1,19'h180, 1,8'h80,0,19'h0,8'h00);
    add(0,0,8'h00,1,0,19'h0,   0,8'h80,1,19'h180,8'h81);
    // redirect to FF: pc+1 wraps, next fetch at 00
    add(1,1,8'hFF,1,0,19'h0,   0,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,1,0,19'h0,   0,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,1,1,19'h1FF, 1,8'hFF,0,19'h0,8'h00);
    add(0,0,8'h00,1,0,19'h0,   0,8'hFF,1,19'h1FF,8'h00);
    add(0,0,8'h00,1,1,19'h100, 1,8'h00,0,19'h0,8'h00);
    add(0,0,8'h00,1,0,19'h0,   0,8'h00,1,19'h100,8'h01);

    foreach (vecs[i]) apply(vecs[i], i);

    // reset asserted mid-WAIT with a word buffered; late ack afterwards ignored
    do_reset();
    redirect = 1'b0; IF_IDwrite = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    #1; check_out(mk(0,0,19'h0,   0,8'h00,0,19'h0,8'h00), 100);
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 19'h100;
    #1; check_out(mk(0,1,19'h100, 1,8'h00,0,19'h0,8'h00), 101);
    @(negedge clk); imem_ack = 1'b0;
    #1; check_out(mk(0,0,19'h0,   0,8'h00,1,19'h100,8'h01), 102);
    @(negedge clk);
    #1; check_out(mk(0,0,19'h0,   1,8'h01,1,19'h100,8'h01), 103);
    #1 rst_n = 1'b0;
    #1; check_out(mk(0,0,19'h0,   0,8'h00,0,19'h0,8'h00), 104);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 19'h1AB;
    #1; check_out(mk(0,1,19'h1AB, 0,8'h00,0,19'h0,8'h00), 105);
    @(negedge clk); imem_ack = 1'b0; imem_rdata = '0;
    #1; check_out(mk(0,0,19'h0,   1,8'h00,0,19'h0,8'h00), 106);
    @(negedge clk);
    #1; check_out(mk(0,0,19'h0,   1,8'h00,0,19'h0,8'h00), 107);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Producer side of the IF/ID pipeline register: owns the fetch PC, requests 19-bit instructions from instruction memory and presents {instruction, pc+1} pairs to IF/ID.
- Holds a 2-entry prefetch buffer so IF/ID stalls (IF_IDwrite=0) do not lose fetched words.
- Takes redirects (branch/jump) from EX: flushes the buffer and discards any in-flight memory response.

Parameters:
PC_W, 8, PC / address width
INSTR_W, 19, instruction width
RESET_PC, 8'h00, fetch PC after reset
NOP_INSTR, 19'h00000, instruction presented when buffer empty or redirecting

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
redirect  input  1  branch/jump taken this cycle
redirect_pc  input  PC_W  new fetch PC when redirect=1
IF_IDwrite  input  1  IF/ID captures outputs this cycle (same signal that drives IF/ID's write enable)
imem_req  output  1  memory request pending
imem_addr  output  PC_W  request address, stable while imem_req=1
imem_ack  input  1  imem_rdata valid; completes request
imem_rdata  input  INSTR_W  fetched instruction
IF_instruction  output  INSTR_W  buffer head instruction, else NOP_INSTR
IF_pc_plus_one  output  PC_W  buffer head pc+1, else 0
IF_valid  output  1  buffer head valid and presented

Behaviour:
- Reset (async, rst_n=0): state=IDLE, fetch_pc=RESET_PC, req_pc=RESET_PC, count=0. Outputs: imem_req=0, imem_addr=RESET_PC, IF_instruction=NOP_INSTR, IF_pc_plus_one=0, IF_valid=0. Reset mid-request abandons the request; a late imem_ack is ignored because state=IDLE.
- Buffer: 2-entry FIFO of {instr, pc+1}, count 0..2.
  - Outputs are combinational from the head: IF_valid = (count>0) && !redirect.
  - When IF_valid=0: IF_instruction=NOP_INSTR, IF_pc_plus_one=0.
  - Pop on IF_valid && IF_IDwrite.
- imem_req = (state==WAIT || state==DRAIN). imem_addr = req_pc.
- State IDLE:
  - redirect: fetch_pc<=redirect_pc, count<=0, stay IDLE.
  - else if count<2, or pop this cycle: req_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^PC_W, so 8'hFF -> 8'h00), go to WAIT.
  - else stay IDLE.
- State WAIT:
  - redirect: fetch_pc<=redirect_pc, count<=0. If imem_ack, go IDLE (data dropped); else go DRAIN.
  - else if imem_ack: push {imem_rdata, req_pc+1}, go IDLE.
  - Push while count==2 cannot occur: issue requires a free slot, and count only decreases while in WAIT.
  - Simultaneous push and pop: count unchanged, FIFO order kept.
- State DRAIN:
  - On imem_ack: discard data, go IDLE.
  - redirect in DRAIN: fetch_pc<=redirect_pc, count stays 0, stay DRAIN unless imem_ack.
- Redirect has priority over pop. A redirect cycle presents NOP/valid=0, so no wrong-path word reaches IF/ID.
- Latency: redirect at cycle N -> imem_req with imem_addr=redirect_pc at N+2. With ack in that cycle, IF_valid=1 at N+3.
- Throughput: one word per 2 cycles with zero-wait memory.
- IF_pc_plus_one wraps: an instruction at 8'hFF carries 8'h00.

Test Plan:
- Reset, zero-wait memory (ack=req, rdata=addr+19'h100), IF_IDwrite=1 -> requests at 00,01,02; IF/ID sees (19'h100,01),(19'h101,02),(19'h102,03), each valid 1 cycle, NOP between.
- IF_IDwrite=0 for 10 cycles from reset -> exactly two requests (00,01); count=2, imem_req=0; head holds (19'h100,01). Release -> 19'h100 then 19'h101 in order, then request 02.
- Memory ack delayed 3 cycles -> imem_addr and imem_req held stable through all wait cycles; exactly one push per ack.
- Redirect to 8'h40 while WAIT (ack not yet) -> DRAIN; returned word discarded; next request addr 8'h40; buffer empty; IF_valid=0 during redirect cycle.
- Redirect coinciding with imem_ack and a pop -> no push, count=0, next request at redirect_pc.
- Redirect to 8'hFF -> instruction delivered with IF_pc_plus_one=8'h00; next request addr 8'h00.
- rst_n asserted low mid-WAIT -> outputs immediately at reset values; a late imem_ack after release does not push.
